// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard/flush controller for the 5-stage MIPS core.
// Combines load-use stalls, EX-resolved branch mispredicts and mult/div
// occupancy into the PC / IF/ID / ID/EX control strobes. It also registers
// the 2-bit branch prediction counter update and keeps two saturating
// performance counters.
//
// Handshake note: there is no valid/ready pair here. Every control output
// is a same-cycle (Mealy) response to the inputs presented in this cycle.
// The only exception is pred_upd_en/pred_buf_upd, which present a branch
// resolved at edge N during cycle N+1.
//
// fsm_state exposes the controller state for observation:
// 0 = RUN, 1 = MD_BUSY.
module hazard_flush_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic             id_md_start,
  input  logic             ex_branch_valid,
  input  logic             ex_branch_taken,
  input  logic             ex_predict,
  input  logic [1:0]       ex_pred_buf,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             redirect_sel,
  output logic             md_abort,
  output logic             pred_upd_en,
  output logic [1:0]       pred_buf_upd,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [0:0]       fsm_state
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

  // MD_LATENCY is at most 15, so 4 bits always hold the remaining count.
  localparam int MD_W = 4;

  logic [0:0]      state;
  logic [0:0]      state_nxt;
  logic [MD_W-1:0] md_cnt;
  logic [MD_W-1:0] md_cnt_nxt;
  logic            mispredict;
  logic            loaduse;

  // A branch is wrong-path whenever the resolved outcome disagrees with the
  // prediction carried down the pipe. A load into r0 never creates a hazard.
  always_comb begin
    mispredict = ex_branch_valid & (ex_branch_taken != ex_predict);
    loaduse    = idex_mem_read & (idex_rt != 5'd0) &
                 ((idex_rt == id_rs) | (id_uses_rt & (idex_rt == id_rt)));
  end

  // Control strobes and next state. The priority order is mispredict first,
  // then mult/div occupancy, then load-use, then a new mult/div issue.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    redirect_sel = 1'b0;
    md_abort     = 1'b0;
    state_nxt    = state;
    md_cnt_nxt   = md_cnt;
    if (!rst_n) begin
      // Hold the pipeline frozen and bubbled while reset is asserted.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (mispredict) begin
      // A wrong-path mult/div is cancelled along with the flush.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      redirect_sel = 1'b1;
      md_abort     = (state == MD_BUSY);
      state_nxt    = RUN;
      md_cnt_nxt   = '0;
    end else if (state == MD_BUSY) begin
      // Load-use and new issues are irrelevant while frozen.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if (md_cnt == '0) begin
        state_nxt = RUN;
      end else begin
        md_cnt_nxt = md_cnt - 1'b1;
      end
    end else if (loaduse) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (id_md_start) begin
      // The issue cycle itself flows normally. The freeze starts next cycle
      // and lasts MD_LATENCY cycles (count MD_LATENCY-1 down to 0).
      state_nxt  = MD_BUSY;
      md_cnt_nxt = MD_W'(MD_LATENCY - 1);
    end
  end

  // FSM state and mult/div occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // Registered 2-bit saturating predictor update for each resolved branch.
  // The last value is held when no branch resolves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_upd_en  <= 1'b0;
      pred_buf_upd <= 2'd0;
    end else begin
      pred_upd_en <= ex_branch_valid;
      if (ex_branch_valid) begin
        if (ex_branch_taken) begin
          pred_buf_upd <= (ex_pred_buf == 2'd3) ? 2'd3 : ex_pred_buf + 2'd1;
        end else begin
          pred_buf_upd <= (ex_pred_buf == 2'd0) ? 2'd0 : ex_pred_buf - 2'd1;
        end
      end
    end
  end

  // Saturating performance counters: stalled cycles and mispredict flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (mispredict && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Scoreboard bench for hazard_flush_ctrl. Each stimulus cycle pushes the
// expected output vector, which a reference model computes, into exp_q.
// A separate monitor pops and compares it at the falling edge.
module tb_hazard_flush_ctrl;

  localparam int MD_LATENCY = 4;
  localparam int CNT_W      = 5;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
  localparam int W          = 9 + 2 * CNT_W + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       id_rs = '0;
  logic [4:0]       id_rt = '0;
  logic             id_uses_rt = 1'b0;
  logic             idex_mem_read = 1'b0;
  logic [4:0]       idex_rt = '0;
  logic             id_md_start = 1'b0;
  logic             ex_branch_valid = 1'b0;
  logic             ex_branch_taken = 1'b0;
  logic             ex_predict = 1'b0;
  logic [1:0]       ex_pred_buf = '0;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             redirect_sel;
  logic             md_abort;
  logic             pred_upd_en;
  logic [1:0]       pred_buf_upd;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [0:0]       fsm_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: cycles of freeze left, counters, predictor regs.
  int m_md_left = 0;
  int m_stall   = 0;
  int m_flush   = 0;
  int m_pen     = 0;
  int m_pupd    = 0;

  hazard_flush_ctrl #(.MD_LATENCY(MD_LATENCY), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .id_md_start(id_md_start), .ex_branch_valid(ex_branch_valid),
    .ex_branch_taken(ex_branch_taken), .ex_predict(ex_predict),
    .ex_pred_buf(ex_pred_buf), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .redirect_sel(redirect_sel), .md_abort(md_abort), .pred_upd_en(pred_upd_en),
    .pred_buf_upd(pred_buf_upd), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .fsm_state(fsm_state)
  );

  // Clock and global time limit.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end

  // Drive one cycle of inputs just after the rising edge, then predict the
  // response from the model and advance the model across the next edge.
  task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic uses_rt, input logic mem_read, input logic [4:0] exrt,
                      input logic md_start, input logic bv, input logic taken,
                      input logic pred, input logic [1:0] pb);
    logic pw, iw, fl, bb, rd, ab, busy, mis, lu;
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    rst_n = rst; id_rs = rs; id_rt = rt; id_uses_rt = uses_rt;
    idex_mem_read = mem_read; idex_rt = exrt; id_md_start = md_start;
    ex_branch_valid = bv; ex_branch_taken = taken; ex_predict = pred; ex_pred_buf = pb;
    if (!rst) begin
      m_md_left = 0; m_stall = 0; m_flush = 0; m_pen = 0; m_pupd = 0;
      e = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0,
           CNT_W'(0), CNT_W'(0), 1'b0};
    end else begin
      mis  = bv && (taken != pred);
      lu   = mem_read && (exrt != 0) && ((exrt == rs) || (uses_rt && exrt == rt));
      busy = (m_md_left > 0);
      pw = 1; iw = 1; fl = 0; bb = 0; rd = 0; ab = 0;
      if (mis) begin
        fl = 1; bb = 1; rd = 1; ab = busy;
      end else if (busy || lu) begin
        pw = 0; iw = 0; bb = 1;
      end
      e = {pw, iw, fl, bb, rd, ab, 1'(m_pen), 2'(m_pupd),
           CNT_W'(m_stall), CNT_W'(m_flush), busy};
      if (mis) m_md_left = 0;
      else if (busy) m_md_left = m_md_left - 1;
      else if (!lu && md_start) m_md_left = MD_LATENCY;
      if (!pw && m_stall < CNT_MAX) m_stall = m_stall + 1;
      if (mis && m_flush < CNT_MAX) m_flush = m_flush + 1;
      m_pen = int'(bv);
      if (bv) m_pupd = taken ? ((pb + 1 > 3) ? 3 : pb + 1) : ((pb == 0) ? 0 : pb - 1);
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare the DUT output vector against the oldest expectation.
  initial begin
    logic [W-1:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {pc_write, if_id_write, if_id_flush, id_ex_bubble, redirect_sel,
             md_abort, pred_upd_en, pred_buf_upd, stall_cnt, flush_cnt, fsm_state};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL ctrl_vec t=%0t got pw%b iw%b fl%b bb%b rd%b ab%b pe%b pu%0d st%0d fc%0d s%0d want pw%b iw%b fl%b bb%b rd%b ab%b pe%b pu%0d st%0d fc%0d s%0d",
                   $time, a[W-1], a[W-2], a[W-3], a[W-4], a[W-5], a[W-6], a[W-7],
                   a[W-8 -: 2], a[2*CNT_W : CNT_W+1], a[CNT_W:1], a[0],
                   e[W-1], e[W-2], e[W-3], e[W-4], e[W-5], e[W-6], e[W-7],
                   e[W-8 -: 2], e[2*CNT_W : CNT_W+1], e[CNT_W:1], e[0]);
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // Load-use on rs, then no hazard when the load targets r0.
    step(1, 5, 0, 0, 1, 5, 0, 0, 0, 0, 0);
    idle();
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // Load-use through rt only when rt is actually read.
    step(1, 1, 7, 1, 1, 7, 0, 0, 0, 0, 0);
    step(1, 1, 7, 0, 1, 7, 0, 0, 0, 0, 0);
    // Mispredict, then saturating predictor updates with correct predictions.
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 3);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle();
    // Mult/div issue with load-use asserted mid-freeze.
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle();
    step(1, 5, 0, 0, 1, 5, 1, 0, 0, 0, 0);
    idle();
    idle();
    idle();
    idle();
    // Mispredict on the second freeze cycle aborts the mult/div.
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle();
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2);
    idle();
    idle();
    // Simultaneous mispredict and load-use.
    step(1, 3, 0, 0, 1, 3, 0, 1, 1, 0, 2);
    idle();
    // Reset mid-freeze.
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    idle();
    // Randomized traffic with occasional resets; saturates the counters.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
